// File: rtl/img_proc_pkg.sv
// Shared width helpers for the image-processing blocks.
// Every helper is a constant function, so modules can use it in localparams and port widths.
package img_proc_pkg;

  // Width of an index that selects one of `lines` slots (at least 1 bit)
  function automatic int slot_idx_w(input int lines);
    return (lines > 32'sd1) ? $clog2(lines) : 32'sd1;
  endfunction

  // Width of a pixel index that must also be able to hold the full line length
  function automatic int pix_idx_w(input int max_line);
    return $clog2(max_line + 32'sd1);
  endfunction

  // Width of a counter that runs from 0 up to and including `lines`
  function automatic int cnt_w(input int lines);
    return $clog2(lines + 32'sd1);
  endfunction

  // Width of a RAM address for `depth` words (at least 1 bit)
  function automatic int addr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle: tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port and one registered read port on a common clock.
// The contents are not reset; a read returns the word one cycle after its address is presented.
module dual_port_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multi_line_buf.sv
// Multi-line video buffer: stores complete input lines in a ring of slots and replays
// the oldest line on request.
// Optional build macro MULTI_LINE_BUF_OVF_DET_EN enables the sticky overflow flag on ovf_o.
// Beats beyond MAX_LINE_SIZE are never written, so overlong lines cannot disturb
// other slots, the pointers or the count.
module multi_line_buf
  import img_proc_pkg::*;
#(
  parameter int MAX_LINE_SIZE = 1920,
  parameter int TDATA_WIDTH   = 32,
  parameter int LINES_CNT     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           pop_line_i,
  input  logic                           flush_line_i,
  axi4_stream_if.slave                   video_i,
  axi4_stream_if.master                  video_o,
  output logic [cnt_w(LINES_CNT)-1:0]    lines_cnt_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic                           ovf_o
);

  localparam int SLOT_W = slot_idx_w(LINES_CNT);
  localparam int PIX_W  = pix_idx_w(MAX_LINE_SIZE);
  localparam int CNT_W  = cnt_w(LINES_CNT);
  localparam int DEPTH  = LINES_CNT * MAX_LINE_SIZE;
  localparam int ADDR_W = addr_w(DEPTH);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LINES_CNT - 1);
  localparam logic [PIX_W-1:0]  MAX_PIX   = PIX_W'(MAX_LINE_SIZE);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(LINES_CNT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Ring pointer advance
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == LAST_SLOT) ? SLOT_W'(0) : s + SLOT_W'(1);
  endfunction

  // Flat RAM address of a pixel inside a slot
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s,
                                                   input logic [PIX_W-1:0]  p);
    return ADDR_W'(s) * ADDR_W'(MAX_LINE_SIZE) + ADDR_W'(p);
  endfunction

  // State
  logic [0:0]             state_q, state_d;
  logic [SLOT_W-1:0]      wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]      rd_slot_q, rd_slot_d;
  logic [PIX_W-1:0]       wr_pix_q, wr_pix_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PIX_W-1:0]       len_q [LINES_CNT];
  logic [PIX_W-1:0]       len_d [LINES_CNT];
  logic [LINES_CNT-1:0]   first_q, first_d;
  logic                   sof_line_q, sof_line_d;
  logic                   tready_q, tready_d;
  logic                   empty_q, empty_d;
  logic                   full_q, full_d;
  logic [PIX_W-1:0]       issue_idx_q, issue_idx_d;
  logic                   p1_valid_q, p1_valid_d;
  logic [PIX_W-1:0]       p1_idx_q, p1_idx_d;
  logic                   p1_last_q, p1_last_d;
  logic                   p1_user_q, p1_user_d;
  logic                   out_valid_q, out_valid_d;
  logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_user_q, out_user_d;

  // Combinational helpers
  logic                   in_hs_s, sof_hs_s, eol_hs_s;
  logic                   line_done_s, adv_s, issue_s;
  logic                   pop_ok_s, flush_ok_s, free_s;
  logic [PIX_W-1:0]       cur_len_s;
  logic                   wr_en_s;
  logic [ADDR_W-1:0]      wr_addr_s, rd_addr_s;
  logic [TDATA_WIDTH-1:0] rd_data_s;

  // Handshake and command qualification shared by the write and read halves
  always_comb begin
    in_hs_s     = video_i.tvalid & tready_q;
    sof_hs_s    = in_hs_s & video_i.tuser;
    eol_hs_s    = in_hs_s & video_i.tlast;
    line_done_s = out_valid_q & video_o.tready & out_last_q;
    adv_s       = ~out_valid_q | video_o.tready;
    pop_ok_s    = (state_q == ST_IDLE) & pop_line_i & (cnt_q != CNT_W'(0)) & ~sof_hs_s;
    flush_ok_s  = (state_q == ST_IDLE) & flush_line_i & ~pop_ok_s & (cnt_q != CNT_W'(0)) & ~sof_hs_s;
    free_s      = line_done_s | flush_ok_s;
    cur_len_s   = len_q[rd_slot_q];
    issue_s     = (state_q == ST_READ) & adv_s & (issue_idx_q < cur_len_s);
  end

  // Write side: slot/pixel pointers, per-slot length and first-after-SOF marker
  always_comb begin
    wr_slot_d  = wr_slot_q;
    wr_pix_d   = wr_pix_q;
    len_d      = len_q;
    first_d    = first_q;
    sof_line_d = sof_line_q;
    wr_en_s    = 1'b0;
    wr_addr_s  = slot_addr(wr_slot_q, wr_pix_q);
    if (sof_hs_s) begin
      // A new frame restarts the ring: the SOF beat always lands at slot 0, pixel 0
      wr_en_s   = 1'b1;
      wr_addr_s = ADDR_W'(0);
      if (video_i.tlast) begin
        len_d[0]   = PIX_W'(1);
        first_d    = LINES_CNT'(1);
        wr_slot_d  = next_slot(SLOT_W'(0));
        wr_pix_d   = PIX_W'(0);
        sof_line_d = 1'b0;
      end else begin
        first_d    = LINES_CNT'(0);
        wr_slot_d  = SLOT_W'(0);
        wr_pix_d   = PIX_W'(1);
        sof_line_d = 1'b1;
      end
    end else if (in_hs_s) begin
      wr_en_s = (wr_pix_q < MAX_PIX);
      if (video_i.tlast) begin
        len_d[wr_slot_q]   = (wr_pix_q < MAX_PIX) ? wr_pix_q + PIX_W'(1) : MAX_PIX;
        first_d[wr_slot_q] = sof_line_q;
        wr_slot_d          = next_slot(wr_slot_q);
        wr_pix_d           = PIX_W'(0);
        sof_line_d         = 1'b0;
      end else begin
        wr_pix_d = (wr_pix_q < MAX_PIX) ? wr_pix_q + PIX_W'(1) : MAX_PIX;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Read side: IDLE/READ FSM, address issue stage and output register
  always_comb begin
    state_d     = state_q;
    rd_slot_d   = rd_slot_q;
    issue_idx_d = issue_idx_q;
    p1_valid_d  = p1_valid_q;
    p1_idx_d    = p1_idx_q;
    p1_last_d   = p1_last_q;
    p1_user_d   = p1_user_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    // While stalled, re-read the word already in flight so the RAM output stays put
    rd_addr_s   = slot_addr(rd_slot_q, adv_s ? issue_idx_q : p1_idx_q);
    if (sof_hs_s) begin
      state_d     = ST_IDLE;
      rd_slot_d   = SLOT_W'(0);
      issue_idx_d = PIX_W'(0);
      p1_valid_d  = 1'b0;
      p1_last_d   = 1'b0;
      p1_user_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_user_d  = 1'b0;
    end else begin
      if (adv_s) begin
        out_valid_d = p1_valid_q;
        out_data_d  = p1_valid_q ? rd_data_s : out_data_q;
        out_last_d  = p1_valid_q & p1_last_q;
        out_user_d  = p1_valid_q & p1_user_q;
        p1_valid_d  = issue_s;
        if (issue_s) begin
          p1_idx_d    = issue_idx_q;
          p1_last_d   = (issue_idx_q == cur_len_s - PIX_W'(1));
          p1_user_d   = (issue_idx_q == PIX_W'(0)) & first_q[rd_slot_q];
          issue_idx_d = issue_idx_q + PIX_W'(1);
        end else begin
          p1_last_d = 1'b0;
          p1_user_d = 1'b0;
        end
      end else begin
        p1_valid_d = p1_valid_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (pop_ok_s) begin
            state_d     = ST_READ;
            issue_idx_d = PIX_W'(0);
          end else if (flush_ok_s) begin
            rd_slot_d = next_slot(rd_slot_q);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          if (line_done_s) begin
            state_d     = ST_IDLE;
            rd_slot_d   = next_slot(rd_slot_q);
            issue_idx_d = PIX_W'(0);
          end else begin
            state_d = ST_READ;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Line count and status flags; tready is computed from the next count so it is never late
  always_comb begin
    cnt_d = cnt_q;
    if (sof_hs_s) begin
      cnt_d = video_i.tlast ? CNT_W'(1) : CNT_W'(0);
    end else if (eol_hs_s & ~free_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (~eol_hs_s & free_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    tready_d = (cnt_d != FULL_CNT);
    empty_d  = (cnt_d == CNT_W'(0));
    full_d   = (cnt_d == FULL_CNT);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_slot_q   <= SLOT_W'(0);
      rd_slot_q   <= SLOT_W'(0);
      wr_pix_q    <= PIX_W'(0);
      cnt_q       <= CNT_W'(0);
      len_q       <= '{default: PIX_W'(0)};
      first_q     <= LINES_CNT'(0);
      sof_line_q  <= 1'b0;
      tready_q    <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      issue_idx_q <= PIX_W'(0);
      p1_valid_q  <= 1'b0;
      p1_idx_q    <= PIX_W'(0);
      p1_last_q   <= 1'b0;
      p1_user_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= TDATA_WIDTH'(0);
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      wr_pix_q    <= wr_pix_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      first_q     <= first_d;
      sof_line_q  <= sof_line_d;
      tready_q    <= tready_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      issue_idx_q <= issue_idx_d;
      p1_valid_q  <= p1_valid_d;
      p1_idx_q    <= p1_idx_d;
      p1_last_q   <= p1_last_d;
      p1_user_q   <= p1_user_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
    end
  end

`ifdef MULTI_LINE_BUF_OVF_DET_EN
  logic ovf_q, ovf_d;

  // Sticky flag: any accepted non-SOF beat past the slot capacity
  always_comb begin
    ovf_d = ovf_q | (in_hs_s & ~sof_hs_s & (wr_pix_q >= MAX_PIX));
  end

  // Overflow flag register, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  dual_port_ram #(
    .DATA_W (TDATA_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (video_i.tdata),
    .rd_en_i   (1'b1),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  assign video_i.tready = tready_q;
  assign video_o.tvalid = out_valid_q;
  assign video_o.tdata  = out_data_q;
  assign video_o.tlast  = out_last_q;
  assign video_o.tuser  = out_user_q;
  assign lines_cnt_o    = cnt_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;

endmodule

// File: tb/tb_multi_line_buf.sv
// Scoreboard bench for multi_line_buf (LINES_CNT=4, MAX_LINE_SIZE=8).
// Build with MULTI_LINE_BUF_OVF_DET_EN defined to exercise the overflow flag.
module tb_multi_line_buf;
  localparam int LINES = 4;
  localparam int MAXL  = 8;
  localparam int W     = 32;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       pop_line_i;
  logic       flush_line_i;
  logic [2:0] lines_cnt_o;
  logic       empty_o, full_o, ovf_o;

  axi4_stream_if #(.TDATA_WIDTH(W)) vin ();
  axi4_stream_if #(.TDATA_WIDTH(W)) vout ();

  multi_line_buf #(
    .MAX_LINE_SIZE (MAXL),
    .TDATA_WIDTH   (W),
    .LINES_CNT     (LINES)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pop_line_i   (pop_line_i),
    .flush_line_i (flush_line_i),
    .video_i      (vin),
    .video_o      (vout),
    .lines_cnt_o  (lines_cnt_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] exp_q[$];    // {tuser, tlast, tdata}
  int          rdy_mode = 0; // 0: always ready, 1: random, 2: never ready

  // Output-side ready driver
  initial begin
    vout.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       vout.tready = 1'b1;
        1:       vout.tready = ($urandom_range(0, 1) == 1);
        default: vout.tready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard and checks stall stability
  task automatic monitor();
    logic [33:0] held;
    logic [33:0] act;
    logic [33:0] e;
    bit          held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      act = {vout.tuser, vout.tlast, vout.tdata};
      if (rst_i === 1'b0 && vout.tvalid === 1'b1) begin
        if (held_v) check("stall_hold", 64'(act), 64'(held));
        if (vout.tready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", act);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", 64'(act), 64'(e));
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = act;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sof, input logic eol);
    int budget;
    budget      = 0;
    vin.tvalid  = 1'b1;
    vin.tdata   = d;
    vin.tuser   = sof;
    vin.tlast   = eol;
    while (vin.tready !== 1'b1 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got tready=0 for 100 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    vin.tvalid = 1'b0;
    vin.tuser  = 1'b0;
    vin.tlast  = 1'b0;
  endtask

  task automatic send_line(input logic [31:0] base, input int n, input logic sof);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 32'(i), sof && (i == 0), (i == n - 1));
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop_line(input logic [31:0] base, input int n, input logic u0, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(u0 && i == 0), (i == n - 1), base + 32'(i)});
    end
    pop_line_i = 1'b1;
    @(posedge clk);
    #1;
    pop_line_i = 1'b0;
    if (chk_lat) begin
      @(posedge clk);
      #1;
      check("pop_lat_1cyc_tvalid", 64'(vout.tvalid), 64'd0);
      @(posedge clk);
      #1;
      check("pop_lat_2cyc_tvalid", 64'(vout.tvalid), 64'd1);
    end
    drain();
  endtask

  initial begin
    int budget;
    rst_i        = 1'b1;
    pop_line_i   = 1'b0;
    flush_line_i = 1'b0;
    vin.tvalid   = 1'b0;
    vin.tdata    = 32'h0;
    vin.tuser    = 1'b0;
    vin.tlast    = 1'b0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(vout.tvalid), 64'd0);
    check("rst_tlast",  64'(vout.tlast),  64'd0);
    check("rst_tuser",  64'(vout.tuser),  64'd0);
    check("rst_tdata",  64'(vout.tdata),  64'd0);
    check("rst_cnt",    64'(lines_cnt_o), 64'd0);
    check("rst_empty",  64'(empty_o),     64'd1);
    check("rst_full",   64'(full_o),      64'd0);
    check("rst_ovf",    64'(ovf_o),       64'd0);
    check("rst_tready", 64'(vin.tready),  64'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("tready_after_rst", 64'(vin.tready), 64'd1);

    // Fill all four slots
    send_line(32'h100, 8, 1'b1);
    send_line(32'h200, 8, 1'b0);
    send_line(32'h300, 8, 1'b0);
    send_line(32'h400, 8, 1'b0);
    check("fill_full",   64'(full_o),      64'd1);
    check("fill_tready", 64'(vin.tready),  64'd0);
    check("fill_cnt",    64'(lines_cnt_o), 64'd4);
    check("fill_empty",  64'(empty_o),     64'd0);

    // Pop line 0 with the sink always ready
    pop_line(32'h100, 8, 1'b1, 1'b1);
    check("pop0_cnt",    64'(lines_cnt_o), 64'd3);
    check("pop0_full",   64'(full_o),      64'd0);
    check("pop0_tready", 64'(vin.tready),  64'd1);

    // Pop line 1 with random back-pressure
    rdy_mode = 1;
    pop_line(32'h200, 8, 1'b0, 1'b0);
    rdy_mode = 0;
    check("pop1_cnt", 64'(lines_cnt_o), 64'd2);

    // Flush the oldest of two lines, then pop the remaining one
    flush_line_i = 1'b1;
    @(posedge clk);
    #1;
    flush_line_i = 1'b0;
    check("flush_cnt", 64'(lines_cnt_o), 64'd1);
    pop_line(32'h400, 8, 1'b0, 1'b0);
    check("flushpop_cnt",   64'(lines_cnt_o), 64'd0);
    check("flushpop_empty", 64'(empty_o),     64'd1);

    // Pop with nothing stored is ignored
    pop_line_i = 1'b1;
    @(posedge clk);
    #1;
    pop_line_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pop_empty_tvalid", 64'(vout.tvalid), 64'd0);

    // SOF arriving while a line is being read aborts the readout
    send_line(32'h500, 8, 1'b0);
    check("abort_pre_cnt", 64'(lines_cnt_o), 64'd1);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    pop_line_i = 1'b1;
    @(posedge clk);
    #1;
    pop_line_i = 1'b0;
    budget = 0;
    while (vout.tvalid !== 1'b1 && budget < 10) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("abort_pre_tvalid", 64'(vout.tvalid), 64'd1);
    send_beat(32'h600, 1'b1, 1'b0);
    check("abort_tvalid", 64'(vout.tvalid),  64'd0);
    check("abort_tlast",  64'(vout.tlast),   64'd0);
    check("abort_cnt",    64'(lines_cnt_o),  64'd0);
    send_beat(32'h601, 1'b0, 1'b0);
    send_beat(32'h602, 1'b0, 1'b0);
    send_beat(32'h603, 1'b0, 1'b1);
    check("abort_line_cnt", 64'(lines_cnt_o), 64'd1);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    pop_line(32'h600, 4, 1'b1, 1'b1);
    check("abort_pop_cnt", 64'(lines_cnt_o), 64'd0);

    // Overlong line (10 beats into 8-word slots)
    send_line(32'h700, 10, 1'b0);
    check("ovl_cnt", 64'(lines_cnt_o), 64'd1);
`ifdef MULTI_LINE_BUF_OVF_DET_EN
    check("ovl_ovf", 64'(ovf_o), 64'd1);
    pop_line(32'h700, 8, 1'b0, 1'b1);
    check("ovl_pop_cnt", 64'(lines_cnt_o), 64'd0);
    check("ovl_ovf_sticky", 64'(ovf_o), 64'd1);
`else
    check("ovl_ovf_off", 64'(ovf_o), 64'd0);
    flush_line_i = 1'b1;
    @(posedge clk);
    #1;
    flush_line_i = 1'b0;
    check("ovl_flush_cnt", 64'(lines_cnt_o), 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_line_buf.md
MULTI_LINE_BUF -- requirements
Module: multi_line_buf

Interface
REQ-001 SHALL have parameter MAX_LINE_SIZE, default 1920, meaning max pixels per line.
REQ-002 SHALL have parameter TDATA_WIDTH, default 32, meaning pixel bus width.
REQ-003 SHALL have parameter LINES_CNT, default 4, meaning number of line slots (legal range 2..16).
REQ-004 SHALL have port clk_i, input, 1 bit: clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port pop_line_i, input, 1 bit: start readout of the oldest stored line.
REQ-007 SHALL have port flush_line_i, input, 1 bit: discard the oldest stored line.
REQ-008 SHALL have port video_i, axi4_stream_if.slave, TDATA_WIDTH: input video (tuser = SOF, tlast = EOL).
REQ-009 SHALL have port video_o, axi4_stream_if.master, TDATA_WIDTH: output lines.
REQ-010 SHALL have port lines_cnt_o, output, $clog2(LINES_CNT+1) bits: complete lines stored.
REQ-011 SHALL have port empty_o, output, 1 bit: lines_cnt_o == 0.
REQ-012 SHALL have port full_o, output, 1 bit: lines_cnt_o == LINES_CNT.
REQ-013 SHALL have port ovf_o, output, 1 bit: sticky line-overflow flag.

Function
REQ-014 SHALL hold a ring of LINES_CNT slots with MAX_LINE_SIZE words each, plus a stored length per slot.
REQ-015 SHALL drive video_i.tready = !full_o as a registered signal, with no combinational dependence on tvalid.
REQ-016 SHALL write each handshaked beat into the current write slot; on tlast it SHALL record the length, advance the write slot modulo LINES_CNT and increment the count.
REQ-017 SHALL run a read FSM with states IDLE -> READ -> IDLE; pop_line_i in IDLE with count > 0 enters READ, and pop in READ or with count 0 is ignored.
REQ-018 SHALL assert video_o.tvalid 2 cycles after an accepted pop (1 cycle RAM latency plus 1 output register), then present one beat per cycle while tready is high.
REQ-019 SHALL hold tdata, tlast and tuser stable while tvalid is high and tready is low.
REQ-020 SHALL assert video_o.tlast on beat number length-1 of the line.
REQ-021 SHALL assert video_o.tuser on beat 0 only when the slot holds the first line after an SOF.
REQ-022 SHALL, on the tlast handshake, free the slot, decrement the count and return to IDLE.
REQ-023 SHALL, for flush_line_i in IDLE with count > 0, free the oldest slot in one cycle; flush is ignored in READ; pop and flush in the same cycle: pop wins.
REQ-024 SHALL leave the count unchanged when a line completes and a slot is freed in the same cycle.
REQ-025 SHALL, on an input SOF handshake, clear all slots, count and ovf-unrelated state, abort READ (tvalid low next cycle, no tlast) and write the SOF beat to slot 0 address 0.
REQ-026 SHALL address RAM as slot*MAX_LINE_SIZE + pixel index, with pixel index width $clog2(MAX_LINE_SIZE+1).

Reset
REQ-027 SHALL reset asynchronously: tvalid, tlast, tuser, tdata = 0; lines_cnt_o = 0; empty_o = 1; full_o = 0; tready = 1 one cycle after release; ovf_o = 0; FSM = IDLE; slot pointers = 0.

Configuration
REQ-028 SHALL honour macro MULTI_LINE_BUF_OVF_DET_EN: when defined, beats beyond MAX_LINE_SIZE are dropped (length saturates at MAX_LINE_SIZE), the line still closes at input tlast, and ovf_o is set until reset.
REQ-029 SHALL, when MULTI_LINE_BUF_OVF_DET_EN is undefined, tie ovf_o to 0; overlong lines then produce undefined slot contents but SHALL NOT corrupt pointers or the count.

Structure
REQ-030 SHALL take width helpers (slot index width, pixel index width, count width) from shared package img_proc_pkg.
REQ-031 SHALL instantiate one dual_port_ram as its only sub-module, with depth LINES_CNT*MAX_LINE_SIZE and read enable always on.

Verification
REQ-032 Bench SHALL cover: LINES_CNT=4, MAX_LINE_SIZE=8, write 4 lines of 8 -> full_o=1, tready=0, lines_cnt_o=4.
REQ-033 Bench SHALL cover: pop with tready=1 -> tvalid 2 cycles later, 8 beats matching line 0, tlast on beat 7, tuser on beat 0, lines_cnt_o=3 after tlast.
REQ-034 Bench SHALL cover: random tready toggling during pop -> data stable under stall, no loss or duplication.
REQ-035 Bench SHALL cover: flush with 2 stored lines, then pop -> line 1 output, lines_cnt_o=0 after tlast.
REQ-036 Bench SHALL cover: SOF handshake mid-READ -> tvalid low next cycle, lines_cnt_o=0, the new line is read correctly.
REQ-037 Bench SHALL cover, with MULTI_LINE_BUF_OVF_DET_EN: a 10-beat line -> ovf_o=1 and readout of 8 beats with tlast on beat 7.
